// File: rtl/mem_bist_pkg.sv
// Shared types and March C- element/op decode for the RAM BIST controller.
// Each element is at most two ops (read then write) at one address.
package mem_bist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam int ERR_CNT_W = 8;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // M0 and M5 are single-op elements, the rest are read/write pairs.
  function automatic logic elem_two_ops(input logic [2:0] elem);
    return (elem != M0) && (elem != M5);
  endfunction

  function automatic logic elem_down(input logic [2:0] elem);
    return (elem == M3) || (elem == M4);
  endfunction

  function automatic logic op_is_read(input logic [2:0] elem, input logic op);
    return (elem == M5) || ((elem != M0) && !op);
  endfunction

  // 1 selects the inverted background for this op.
  function automatic logic op_pol(input logic [2:0] elem, input logic op);
    case (elem)
      M1, M3:  return op;
      M2, M4:  return !op;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data checker: expected data registered one cycle after the read, compare committed the cycle after.
// Keeps first-failure diagnostics and a saturating miscompare count; never stalls.
module bist_checker
  import mem_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 rd_vld_i,
  input  logic [WIDTH-1:0]     rd_exp_i,
  input  logic [AW-1:0]        rd_addr_i,
  input  logic [2:0]           rd_elem_i,
  input  logic [WIDTH-1:0]     rd_data_i,
  output logic                 fail_o,
  output logic [AW-1:0]        fail_addr_o,
  output logic [WIDTH-1:0]     fail_data_o,
  output logic [2:0]           fail_elem_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic                 vld_q, vld_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [2:0]           elem_q, elem_d;
  logic                 fail_q, fail_d;
  logic [AW-1:0]        faddr_q, faddr_d;
  logic [WIDTH-1:0]     fdata_q, fdata_d;
  logic [2:0]           felem_q, felem_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 miss;

  always_comb begin
    vld_d   = rd_vld_i && !clear_i;
    exp_d   = rd_exp_i;
    addr_d  = rd_addr_i;
    elem_d  = rd_elem_i;
    miss    = vld_q && (rd_data_i != exp_q);
    fail_d  = fail_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    felem_d = felem_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      fdata_d = '0;
      felem_d = '0;
      cnt_d   = '0;
    end else if (miss) begin
      if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
      // Only the first miscompare is kept for diagnosis.
      if (!fail_q) begin
        fail_d  = 1'b1;
        faddr_d = addr_q;
        fdata_d = rd_data_i;
        felem_d = elem_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      exp_q   <= '0;
      addr_q  <= '0;
      elem_q  <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      felem_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      addr_q  <= addr_d;
      elem_q  <= elem_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      felem_q <= felem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = faddr_q;
  assign fail_data_o = fdata_q;
  assign fail_elem_o = felem_q;
  assign err_cnt_o   = cnt_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST sequencer for a single-port RAM: one op per cycle, 10*2^AW ops, then one drain cycle.
// done rises 10N+1 cycles after the accepted start; start is ignored while busy.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               AW    = 4,
  parameter logic [WIDTH-1:0] BG    = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [WIDTH-1:0]     mem_wrData,
  input  logic [WIDTH-1:0]     mem_rdData,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [AW-1:0]        fail_addr,
  output logic [WIDTH-1:0]     fail_data,
  output logic [2:0]           fail_elem,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e        state_q;
  logic [2:0]    elem_q;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic          busy_q, done_q;

  logic             run, is_rd, last_op, last_addr, start_acc;
  logic [2:0]       elem_nxt;
  logic [WIDTH-1:0] pat;

  always_comb begin
    run       = (state_q == ST_RUN);
    is_rd     = op_is_read(elem_q, op_q);
    pat       = op_pol(elem_q, op_q) ? ~BG : BG;
    last_op   = !elem_two_ops(elem_q) || op_q;
    last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == '1);
    elem_nxt  = elem_q + 3'd1;
    start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  assign mem_we     = run && !is_rd;
  assign mem_addr   = run ? addr_q : '0;
  assign mem_wrData = (run && !is_rd) ? pat : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      elem_q  <= M0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            elem_q  <= M0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!last_op) begin
            op_q <= 1'b1;
          end else begin
            op_q <= 1'b0;
            if (last_addr) begin
              if (elem_q == M5) begin
                state_q <= ST_DRAIN;
              end else begin
                // Each element restarts at its own first address, no wrap.
                elem_q <= elem_nxt;
                addr_q <= elem_down(elem_nxt) ? '1 : '0;
              end
            end else begin
              addr_q <= elem_down(elem_q) ? addr_q - AW'(1) : addr_q + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  bist_checker #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_acc),
    .rd_vld_i   (run && is_rd),
    .rd_exp_i   (pat),
    .rd_addr_i  (addr_q),
    .rd_elem_i  (elem_q),
    .rd_data_i  (mem_rdData),
    .fail_o     (fail),
    .fail_addr_o(fail_addr),
    .fail_data_o(fail_data),
    .fail_elem_o(fail_elem),
    .err_cnt_o  (err_cnt)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench: AW=2 controller against a small RAM with selectable read faults,
// plus an AW=8 controller against an all-0xFF RAM for counter saturation.
module tb_mem_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;

  logic       we1, busy1, done1, fail1;
  logic [1:0] addr1, faddr1;
  logic [7:0] wd1, rd1, fdata1, err1;
  logic [2:0] felem1;

  logic       we2, busy2, done2, fail2;
  logic [7:0] addr2, faddr2, wd2, fdata2, err2;
  logic [2:0] felem2;

  logic [7:0] ram1 [4];
  logic [1:0] ra1;
  int         fault;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_we [40];
  int exp_ad [40];
  int exp_wd [40];

  always #5 clk = ~clk;

  mem_bist_ctrl #(.WIDTH(8), .AW(2), .BG(8'h00)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .mem_we(we1), .mem_addr(addr1), .mem_wrData(wd1), .mem_rdData(rd1),
    .busy(busy1), .done(done1), .fail(fail1), .fail_addr(faddr1),
    .fail_data(fdata1), .fail_elem(felem1), .err_cnt(err1)
  );

  mem_bist_ctrl #(.WIDTH(8), .AW(8), .BG(8'h00)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .mem_we(we2), .mem_addr(addr2), .mem_wrData(wd2), .mem_rdData(8'hFF),
    .busy(busy2), .done(done2), .fail(fail2), .fail_addr(faddr2),
    .fail_data(fdata2), .fail_elem(felem2), .err_cnt(err2)
  );

  // RAM: registered address/write, read data valid the cycle after the read.
  always @(posedge clk) begin
    if (we1) ram1[addr1] <= wd1;
    ra1 <= addr1;
  end

  always_comb begin
    rd1 = ram1[ra1];
    if (fault == 1 && ra1 == 2'd2) rd1 = rd1 | 8'h08;
    if (fault == 2 && ra1 == 2'd1) rd1 = 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry/exit invariant: 1 time unit after a rising edge.
  task automatic run_test(input int inj);
    int n;
    int busy_n;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("start_busy", 32'(busy1), 32'd1);
    chk("start_done_clr", 32'(done1), 32'd0);
    chk("start_fail_clr", 32'(fail1), 32'd0);
    chk("start_err_clr", 32'(err1), 32'd0);
    n = 0;
    busy_n = 0;
    while (done1 !== 1'b1 && n < 200) begin
      if (busy1 === 1'b1) busy_n++;
      if (n < 40) begin
        chk($sformatf("we[%0d]", n), 32'(we1), 32'(exp_we[n]));
        chk($sformatf("addr[%0d]", n), 32'(addr1), 32'(exp_ad[n]));
        chk($sformatf("wd[%0d]", n), 32'(wd1), 32'(exp_wd[n]));
      end
      if (n == inj) start1 = 1'b1;
      if (n == inj + 1) start1 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start1 = 1'b0;
    chk("done_cycles", 32'(n), 32'd41);
    chk("busy_cycles", 32'(busy_n), 32'd41);
    chk("end_busy", 32'(busy1), 32'd0);
    chk("end_we_idle", 32'(we1), 32'd0);
  endtask

  initial begin
    int k;
    int n2;
    int nops [6] = '{1, 2, 2, 2, 2, 1};
    bit dn   [6] = '{0, 0, 0, 1, 1, 0};
    bit rdt  [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit valt [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    k = 0;
    for (int e = 0; e < 6; e++)
      for (int ai = 0; ai < 4; ai++)
        for (int o = 0; o < nops[e]; o++) begin
          exp_we[k] = rdt[e][o] ? 0 : 1;
          exp_ad[k] = dn[e] ? 3 - ai : ai;
          exp_wd[k] = rdt[e][o] ? 0 : (valt[e][o] ? 8'hFF : 8'h00);
          k++;
        end

    fault = 0;
    rst = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_fail", 32'(fail1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fault-free pass
    run_test(-1);
    chk("clean_done", 32'(done1), 32'd1);
    chk("clean_fail", 32'(fail1), 32'd0);
    chk("clean_err", 32'(err1), 32'd0);

    // Bit 3 stuck at 1 at addr 2: fails in M1, M3, M5 reads of zero
    fault = 1;
    run_test(-1);
    chk("sa1_fail", 32'(fail1), 32'd1);
    chk("sa1_elem", 32'(felem1), 32'd1);
    chk("sa1_addr", 32'(faddr1), 32'd2);
    chk("sa1_data", 32'(fdata1), 32'h08);
    chk("sa1_err", 32'(err1), 32'd3);

    // Restart after DONE with addr 1 reading A5: every read at addr 1 fails
    fault = 2;
    run_test(-1);
    chk("a5_fail", 32'(fail1), 32'd1);
    chk("a5_elem", 32'(felem1), 32'd1);
    chk("a5_addr", 32'(faddr1), 32'd1);
    chk("a5_data", 32'(fdata1), 32'hA5);
    chk("a5_err", 32'(err1), 32'd5);

    // start during RUN must be ignored
    fault = 0;
    run_test(10);
    chk("inj_fail", 32'(fail1), 32'd0);
    chk("inj_err", 32'(err1), 32'd0);

    // Asynchronous reset mid-test, after a failing run so fail is set first
    fault = 2;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("mid_busy_pre", 32'(busy1), 32'd1);
    chk("mid_fail_pre", 32'(fail1), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_fail", 32'(fail1), 32'd0);
    chk("abort_err", 32'(err1), 32'd0);
    chk("abort_faddr", 32'(faddr1), 32'd0);
    chk("abort_fdata", 32'(fdata1), 32'd0);
    chk("abort_felem", 32'(felem1), 32'd0);
    chk("abort_we", 32'(we1), 32'd0);
    chk("abort_addr", 32'(addr1), 32'd0);
    chk("abort_wd", 32'(wd1), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_busy", 32'(busy1), 32'd0);
    fault = 0;
    run_test(-1);
    chk("post_abort_fail", 32'(fail1), 32'd0);
    chk("post_abort_err", 32'(err1), 32'd0);
    chk("post_abort_done", 32'(done1), 32'd1);

    // Saturation: AW=8, every read returns FF
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n2 = 0;
    while (done2 !== 1'b1 && n2 < 4000) begin
      @(posedge clk); #1;
      n2++;
    end
    chk("sat_cycles", 32'(n2), 32'd2561);
    chk("sat_err", 32'(err2), 32'd255);
    chk("sat_fail", 32'(fail2), 32'd1);
    chk("sat_elem", 32'(felem2), 32'd1);
    chk("sat_addr", 32'(faddr2), 32'd0);
    chk("sat_data", 32'(fdata2), 32'hFF);
    chk("sat_busy", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- March C- built-in self-test controller for the team's synchronous single-port RAM; sits directly upstream of the RAM and drives its we/addr/wrData inputs.
- Consumes the RAM's rdData, compares it against expected data and reports pass/fail plus first-failure diagnostics.
- Used at bring-up and on demand, while the functional path to the RAM is muxed off (mux is outside this block).

Parameters:
- WIDTH, 8, RAM data width in bits.
- AW, 4, RAM address width; N = 2^AW words are tested.
- BG, {WIDTH{1'b0}}, background pattern. "0" means BG and "1" means ~BG.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse to begin a test; honoured only in IDLE or DONE.
- mem_we  output  1  RAM write enable.
- mem_addr  output  AW  RAM address.
- mem_wrData  output  WIDTH  RAM write data.
- mem_rdData  input  WIDTH  RAM read data.
- busy  output  1  high while a test is running.
- done  output  1  sticky; set at test end, cleared by the next accepted start.
- fail  output  1  sticky; set on the first miscompare.
- fail_addr  output  AW  address of the first miscompare.
- fail_data  output  WIDTH  read data at the first miscompare.
- fail_elem  output  3  march element index (0-5) of the first miscompare.
- err_cnt  output  8  total miscompares, saturating at 255.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset is asynchronous, so a reset mid-test aborts immediately. RAM contents are then undefined, and a new start is required.
- RAM contract: the RAM registers we/addr/wrData on the clk edge. rdData for a read presented in cycle t is valid during cycle t+1, provided the registered we is 0. Presenting a write in cycle t+1 does not disturb that data.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN: start=1 at an edge. Clears fail, err_cnt, fail_* and done, and sets busy.
  - RUN -> DRAIN: after the last op is issued.
  - DRAIN: one cycle with no RAM op, to check the final read.
  - DRAIN -> DONE: sets done and clears busy.
  - start while in RUN or DRAIN is ignored.
- March elements, one op per cycle, with the address changing only after the last op of an element at that address:
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
- "up" runs addresses 0..N-1 and "down" runs N-1..0. Each element starts at its own first address; the counter does not wrap between elements.
- Total ops: 10N. With start accepted at edge k, the first op is driven in cycle k+1 and done rises at edge k+10N+1.
- Outside RUN: mem_we=0, mem_addr=0, mem_wrData=0.
- Read ops drive mem_we=0 and mem_wrData=0. Write ops drive mem_we=1 with the pattern.
- Check pipeline:
  - A read issued in cycle t loads exp/addr/elem/valid registers at edge t+1.
  - The compare uses mem_rdData during cycle t+1 and is committed at edge t+2.
- On a miscompare:
  - err_cnt increments, saturating at 255.
  - If fail=0: fail is set and fail_addr/fail_data/fail_elem are captured.
  - Later failures never overwrite the fail_* fields.
- The test always runs to completion; it does not stop on the first error.

Decomposition:
- Package mem_bist_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Element index constants M0..M5.
  - Per-element op count (1 or 2) and direction bit.
  - Per-op read/write flag and data polarity.
  - ERR_CNT_W = 8.
- Sub-module bist_checker: holds the expected-data/address/element pipeline registers, the comparator, the sticky fail capture and the saturating counter.
- The top level holds the sequencer FSM and the address/op counters.

Test Plan:
- Fault-free RAM model, AW=2, WIDTH=8, BG=0, start at edge k:
  - mem_we pattern matches March C- exactly (40 ops);
  - done rises at edge k+41 and busy is high for 41 cycles;
  - fail=0 and err_cnt=0.
- Stuck-at-1 on bit 3 at addr 2, same config -> fail=1, fail_elem=1, fail_addr=2, fail_data=8'h08, err_cnt=3 (failures at M1, M3 and M5 r0).
- Addr 1 always reads 8'hA5 -> first failure in M1 with fail_addr=1 and fail_data=8'hA5; err_cnt=5.
- rst pulsed low at op 15 -> all outputs are 0 asynchronously. A later start runs a full test with done at +41 cycles and no stale fail.
- start pulsed during RUN -> ignored, and done timing is unchanged.
- A second start after DONE -> done, fail and err_cnt clear at the start edge.
- Saturation: AW=8 with every word stuck at 8'hFF -> err_cnt=255 and fail_elem=1.
